// File: rtl/trap_seq_ctrl.sv
// Machine-mode trap entry / mret sequencer: walks mstatus, mtvec/mepc and mcause
// through a single-read, dual-write CSR port and then redirects the PC.
module trap_seq_ctrl #(
    parameter logic [11:0] ADDR_MSTATUS = 12'h300,
    parameter logic [11:0] ADDR_MTVEC   = 12'h305,
    parameter logic [11:0] ADDR_MEPC    = 12'h341,
    parameter logic [11:0] ADDR_MCAUSE  = 12'h342
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_mret,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_cause,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic        csr_we1,
    output logic [11:0] csr_waddr1,
    output logic [31:0] csr_wdata1,
    output logic        csr_we2,
    output logic [11:0] csr_waddr2,
    output logic [31:0] csr_wdata2,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_STAT,
        RD_VEC,
        RD_EPC,
        WR_CSR,
        WR_STAT,
        REDIR
    } state_e;

    state_e      state_q, state_d;
    logic        mret_q, mret_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] stat_q, stat_d;
    logic [31:0] target_q, target_d;

    // Trap entry stacks MIE into MPIE, disables interrupts and records M-mode as MPP.
    function automatic logic [31:0] stat_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mret restores MIE from MPIE, re-arms MPIE and drops MPP to U-mode.
    function automatic logic [31:0] stat_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

    // NOTE: every captured register is cleared by reset so an aborted sequence
    // leaves no stale pc/cause/target that a later redirect could expose.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mret_q   <= 1'b0;
            pc_q     <= '0;
            cause_q  <= '0;
            stat_q   <= '0;
            target_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q  <= state_d;
            mret_q   <= mret_d;
            pc_q     <= pc_d;
            cause_q  <= cause_d;
            stat_q   <= stat_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        mret_d      = mret_q;
        pc_d        = pc_q;
        cause_d     = cause_q;
        stat_d      = stat_q;
        target_d    = target_q;
        csr_raddr   = 12'h000;
        csr_we1     = 1'b0;
        csr_waddr1  = 12'h000;
        csr_wdata1  = '0;
        csr_we2     = 1'b0;
        csr_waddr2  = 12'h000;
        csr_wdata2  = '0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        req_ready   = (state_q == IDLE);
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mret_d  = req_mret;
                    pc_d    = req_pc;
                    cause_d = req_cause;
                    state_d = RD_STAT;
                end
            end
            RD_STAT: begin
                csr_raddr = ADDR_MSTATUS;
                stat_d    = csr_rdata;
                state_d   = mret_q ? RD_EPC : RD_VEC;
            end
            RD_VEC: begin
                csr_raddr = ADDR_MTVEC;
                target_d  = {csr_rdata[31:2], 2'b00};
                state_d   = WR_CSR;
            end
            RD_EPC: begin
                csr_raddr = ADDR_MEPC;
                target_d  = {csr_rdata[31:2], 2'b00};
                state_d   = WR_STAT;
            end
            WR_CSR: begin
                csr_we1    = 1'b1;
                csr_waddr1 = ADDR_MEPC;
                csr_wdata1 = pc_q;
                csr_we2    = 1'b1;
                csr_waddr2 = ADDR_MCAUSE;
                csr_wdata2 = cause_q;
                state_d    = WR_STAT;
            end
            WR_STAT: begin
                csr_we1    = 1'b1;
                csr_waddr1 = ADDR_MSTATUS;
                csr_wdata1 = mret_q ? stat_on_mret(stat_q) : stat_on_trap(stat_q);
                state_d    = REDIR;
            end
            REDIR: begin
                redir_valid = 1'b1;
                redir_pc    = target_q;
                if (redir_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/trap_seq_ctrl.md
TRAP_SEQ_CTRL -- requirements
Module: trap_seq_ctrl

Interface
REQ-001 Parameter ADDR_MSTATUS, 12'h300, CSR address of mstatus.
REQ-002 Parameter ADDR_MTVEC, 12'h305, CSR address of mtvec.
REQ-003 Parameter ADDR_MEPC, 12'h341, CSR address of mepc.
REQ-004 Parameter ADDR_MCAUSE, 12'h342, CSR address of mcause.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 req_valid  in  1  trap/return request present.
REQ-009 req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
REQ-010 req_mret  in  1  0 = trap entry (ecall/exception), 1 = mret.
REQ-011 req_pc  in  32  PC of the trapping instruction; ignored for mret.
REQ-012 req_cause  in  32  mcause value for trap entry; ignored for mret.
REQ-013 csr_raddr  out  12  CSR read address to the CSR file.
REQ-014 csr_rdata  in  32  combinational CSR read data for csr_raddr.
REQ-015 csr_we1 / csr_waddr1 / csr_wdata1  out  1/12/32  CSR write port 1.
REQ-016 csr_we2 / csr_waddr2 / csr_wdata2  out  1/12/32  CSR write port 2.
REQ-017 redir_valid  out  1  PC redirect request to the PC register.
REQ-018 redir_ready  in  1  redirect consumed when redir_valid && redir_ready at a rising edge.
REQ-019 redir_pc  out  32  redirect target.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states SHALL be IDLE, RD_STAT, RD_VEC, RD_EPC, WR_CSR, WR_STAT, REDIR.
REQ-022 req_ready SHALL equal (state == IDLE); on acceptance req_mret, req_pc, req_cause SHALL be latched and state SHALL go to RD_STAT.
REQ-023 RD_STAT: csr_raddr = ADDR_MSTATUS, csr_rdata latched as mstatus copy; next RD_VEC if trap entry, RD_EPC if mret.
REQ-024 RD_VEC: csr_raddr = ADDR_MTVEC, target latched as {csr_rdata[31:2],2'b00}; next WR_CSR.
REQ-025 WR_CSR (trap only): csr_we1=1, waddr1=ADDR_MEPC, wdata1=latched pc; csr_we2=1, waddr2=ADDR_MCAUSE, wdata2=latched cause; next WR_STAT.
REQ-026 RD_EPC (mret only): csr_raddr = ADDR_MEPC, target latched as {csr_rdata[31:2],2'b00}; next WR_STAT.
REQ-027 WR_STAT trap: csr_we1=1, waddr1=ADDR_MSTATUS, wdata1 = mstatus copy with bit7(MPIE)=old bit3, bit3(MIE)=0, bits12:11(MPP)=2'b11, other bits unchanged.
REQ-028 WR_STAT mret: same port, wdata1 = copy with bit3=old bit7, bit7=1, bits12:11=2'b00, other bits unchanged; next REDIR for both.
REQ-029 REDIR: redir_valid=1, redir_pc=latched target, held stable until redir_ready; on handshake next IDLE.
REQ-030 Outside the states above, csr_we1=csr_we2=0, csr_raddr=12'h000, redir_valid=0; each write strobe SHALL last exactly one cycle.
REQ-031 Latency: trap accepted at edge N -> redir_valid first high cycle N+5; mret -> N+4 (redir_ready held high).
REQ-032 req_valid while busy SHALL be ignored and not queued; request inputs changing mid-sequence SHALL have no effect.
REQ-033 Back-to-back: a request presented in the cycle after the REDIR handshake SHALL be accepted (no dead cycle beyond IDLE).

Reset
REQ-034 rst low SHALL immediately force IDLE, all latches to 0, outputs: req_ready=1 (while rst high), busy=0, csr_we1=csr_we2=0, redir_valid=0, redir_pc=0, csr_raddr=0, all write addr/data=0.
REQ-035 Reset mid-sequence SHALL abort with no further CSR write or redirect; after release state is IDLE.

Verification
REQ-036 Trap: mstatus=0x00000008, mtvec=0x80001001, pc=0x80000100, cause=11 -> mepc=0x80000100, mcause=11, mstatus=0x00001880, redir_pc=0x80001000 at N+5.
REQ-037 mret: mstatus=0x00001880, mepc=0x80000104 -> mstatus=0x00000088, redir_pc=0x80000104 at N+4.
REQ-038 Backpressure: redir_ready low 3 cycles -> redir_valid/redir_pc stable, no CSR writes, req_ready=0 throughout.
REQ-039 Busy: req_valid pulsed during WR_CSR -> ignored; exactly one sequence of writes observed.
REQ-040 Reset asserted in WR_STAT -> no mstatus write, no redirect; next trap request completes normally.
REQ-041 Back-to-back trap then mret with redir_ready=1 -> second req accepted at the cycle following the first REDIR handshake.
